// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front-end: 10-bit command frames in, 8-bit read reply out
module spi_slave_if (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       rx_valid,
  output logic [9:0] rx_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  bit_cnt;
  logic [9:0]  shift;
  logic [7:0]  tx_shift;
  logic        rd_addr_done;
  logic        in_frame;
  logic        rx_phase;
  logic        abort;

  // bit_cnt counts frame bits 8..0 (0..8); 9 means the frame is fully received.
  assign in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign rx_phase = in_frame && (bit_cnt < 4'd9);
  assign abort    = (state != IDLE) && ss_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode: the command is chosen by the first frame bit and the read-address flag
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!ss_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (ss_n)              next_state = IDLE;
        else if (!mosi)        next_state = WRITE;
        else if (rd_addr_done) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (ss_n) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: frame shifting, rx handoff, read-address flag and reply serialiser.
  // The reply register is loaded with {data[6:0], 1} so the trailing marker bit
  // tells how many bits remain: while it sits in [6:0] bits are still pending,
  // once it reaches bit 7 the reply is done and the register is nonzero, which
  // also closes the tx_valid capture window.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= 4'd0;
      shift        <= 10'd0;
      tx_shift     <= 8'd0;
      rd_addr_done <= 1'b0;
      miso         <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= 10'd0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        bit_cnt  <= 4'd0;
        tx_shift <= 8'd0;
        miso     <= 1'b0;
      end else begin
        if (state == CHK_CMD) begin
          shift   <= {shift[8:0], mosi};
          bit_cnt <= 4'd0;
        end
        if (rx_phase) begin
          shift   <= {shift[8:0], mosi};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            rx_data  <= {shift[8:0], mosi};
            rx_valid <= 1'b1;
            if (state == READ_ADD) rd_addr_done <= 1'b1;
          end
        end
        if ((state == READ_DATA) && (bit_cnt == 4'd9)) begin
          if (tx_shift == 8'd0) begin
            if (tx_valid) begin
              tx_shift     <= {tx_data[6:0], 1'b1};
              miso         <= tx_data[7];
              rd_addr_done <= 1'b0;
            end
          end else if (tx_shift[6:0] != 7'd0) begin
            miso     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end else begin
            miso <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - directed self-checking bench for spi_slave_if
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;

  int         errors = 0;
  int         checks = 0;
  int         pulses;
  logic       miso_seen;
  logic [7:0] got;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given pins; outputs are observed 1ns after the edge.
  task automatic step(input logic s, input logic m);
    ss_n = s;
    mosi = m;
    @(posedge clk);
    #1;
    if (rx_valid) pulses++;
    if (miso)     miso_seen = 1'b1;
  endtask

  // E0 with ss_n low, then the first nbits frame bits MSB first.
  task automatic send(input logic [9:0] f, input int nbits);
    pulses    = 0;
    miso_seen = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 9; i > 9 - nbits; i--) step(1'b0, f[i]);
  endtask

  // tx_valid pulse on the edge after rx_valid, then collect the 8 miso bits.
  task automatic reply(input logic [7:0] d, output logic [7:0] g);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1'b0, 1'b0);
    g[7]     = miso;
    tx_valid = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      step(1'b0, 1'b0);
      g[i] = miso;
    end
    step(1'b0, 1'b0);
    check("miso_after_reply", miso, 0);
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("reset_miso", miso, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 10'h000);
    rst = 1'b0;
    step(1'b1, 1'b0);

    send(10'h03C, 10);
    check("first_rx_data", rx_data, 10'h03C);
    check("first_pulses", pulses, 1);
    step(1'b1, 1'b0);
    check("rx_valid_one_cycle", rx_valid, 0);

    send(10'h0AB, 5);
    rst = 1'b1;
    step(1'b0, 1'b1);
    check("midrst_miso", miso, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_data", rx_data, 10'h000);
    rst = 1'b0;
    step(1'b1, 1'b0);
    send(10'h0AB, 10);
    check("post_rst_rx_data", rx_data, 10'h0AB);
    check("post_rst_pulses", pulses, 1);
    step(1'b1, 1'b0);

    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    send(10'h005, 10);
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    check("wr_addr_rx_data", rx_data, 10'h005);
    check("wr_addr_pulses", pulses, 1);
    check("wr_addr_miso_quiet", miso_seen, 0);
    step(1'b1, 1'b0);

    send(10'h205, 10);
    check("rd_addr_rx_data", rx_data, 10'h205);
    check("rd_addr_pulses", pulses, 1);
    tx_valid = 1'b1;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    step(1'b0, 1'b0);
    check("rd_addr_miso_quiet", miso_seen, 0);
    step(1'b1, 1'b0);

    send(10'h300, 10);
    check("rd_data_rx_data", rx_data, 10'h300);
    reply(8'hA5, got);
    check("rd_data_reply", got, 8'hA5);
    check("rd_data_pulses", pulses, 1);
    step(1'b1, 1'b0);

    send(10'h300, 10);
    check("flag_clr_pulses", pulses, 1);
    reply(8'hA5, got);
    check("flag_clr_no_reply", got, 8'h00);
    step(1'b1, 1'b0);

    send(10'h3FF, 4);
    step(1'b1, 1'b0);
    check("rd_abort_pulses", pulses, 0);
    check("rd_abort_rx_data", rx_data, 10'h300);
    send(10'h3FF, 10);
    check("persist_rx_data", rx_data, 10'h3FF);
    reply(8'h3C, got);
    check("persist_reply", got, 8'h3C);
    step(1'b1, 1'b0);

    send(10'h0F0, 6);
    step(1'b1, 1'b0);
    check("wr_abort_pulses", pulses, 0);
    check("wr_abort_rx_data", rx_data, 10'h3FF);
    send(10'h1C3, 10);
    check("after_abort_rx_data", rx_data, 10'h1C3);
    check("after_abort_pulses", pulses, 1);
    step(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI slave front-end that sits between the serial SPI pins and the command-driven RAM.
- Deserialises MOSI frames into 10-bit command words on `rx_data`/`rx_valid` (bits [9:8] are the command: 00 write address, 01 write data, 10 read address, 11 read data).
- On a read-data command, takes the RAM's 8-bit `tx_data`/`tx_valid` reply and shifts it out on MISO.
- The system clock is the SPI clock: MOSI is sampled, and MISO updated, on each `clk` rising edge.

## Interface
Parameters:
- none; frame width is fixed at 10 bits, reply width at 8 bits.

Ports:
- clk  in  1  system/SPI clock; all logic on the rising edge.
- rst  in  1  **reset: one clock; reset is synchronous and active-high.**
- ss_n  in  1  slave select, active low; framing signal.
- mosi  in  1  serial data from the master, MSB first.
- miso  out  1  serial reply to the master, MSB first; 0 when not transmitting.
- rx_valid  out  1  one-cycle pulse: `rx_data` holds a complete frame.
- rx_data  out  10  last received frame; held until the next frame completes.
- tx_valid  in  1  RAM read data is valid (single-cycle pulse from the RAM).
- tx_data  in  8  RAM read data.

## Operation
- State machine states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal registers: 4-bit bit counter, 10-bit shift register, 8-bit tx shift register, `rd_addr_done` flag.
- IDLE:
  - ss_n=0 → CHK_CMD.
  - MOSI on this edge is ignored.
- CHK_CMD:
  - ss_n=1 → IDLE.
  - Otherwise shift MOSI into bit 9 of the frame, then branch:
    - mosi=0 → WRITE.
    - mosi=1 and rd_addr_done=0 → READ_ADD.
    - mosi=1 and rd_addr_done=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift in 9 further bits (frame bits 8..0), one per edge.
  - On the edge sampling bit 0:
    - `rx_data` ← {shift[8:0], mosi}.
    - `rx_valid`=1 for exactly one cycle.
  - In READ_ADD, `rd_addr_done` is set on that same edge.
- After receive in WRITE / READ_ADD:
  - Further MOSI bits are ignored until ss_n=1, which returns the FSM to IDLE.
- READ_DATA reply phase, after receive:
  - Wait for tx_valid=1. On that edge capture `tx_data` and drive miso=tx_data[7].
  - The next 7 edges drive bits 6..0; then miso=0.
  - `rd_addr_done` is cleared when the reply is captured.
  - tx_valid seen outside this wait window is ignored.
- Command decoding is by FSM path only: bit 8 is forwarded unchecked in `rx_data`. Address/data interpretation belongs to the RAM.
- Abort: ss_n=1 in any non-IDLE state, on any edge:
  - Next state is IDLE; bit counter and tx shift are cleared; miso=0.
  - No `rx_valid` is issued for a partial frame.
  - `rd_addr_done` keeps its value, except that a reply already captured has already cleared it.
- Reset (rst=1 at a rising edge), including mid-frame:
  - State=IDLE; miso=0, rx_valid=0, rx_data=0.
  - Counters, shift registers and `rd_addr_done` = 0.
  - Reset has priority over ss_n.

## Timing
- Let edge E0 be the first edge sampling ss_n=0 in IDLE.
- Bit 9 is sampled at E1 and bits 8..0 at E2..E10.
- `rx_valid` is high in the cycle after E10 (registered output). Minimum frame = 11 edges with ss_n low.
- Read-data reply:
  - If `tx_valid` is sampled at edge Ek, miso carries bit 7 during Ek..Ek+1 and bit 0 during Ek+7..Ek+8.
  - ss_n must remain low through Ek+8.
- With the RAM as specified, `tx_valid` arrives one edge after `rx_valid` is sampled. A read-data transaction is therefore ss_n low for 20 edges.
- A new frame requires ss_n high for at least one edge; back-to-back frames without deassertion are not recognised.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert rst mid-WRITE frame → next edge: miso=0, rx_valid=0, rx_data=10'h000; a following full frame is received normally.
- **Write address:** send frame 10'b00_0000_0101 → rx_valid pulses once, rx_data=10'h005, miso stays 0; ss_n high → IDLE.
- **Read address:** send 10'b10_0000_0101 → rx_data=10'h205, rx_valid pulse, `rd_addr_done`=1. Next frame starting with 1 then enters READ_DATA.
- **Read data:** send 10'b11_0000_0000, then model tx_valid=1 with tx_data=8'hA5 one edge after rx_valid → miso sequence 1,0,1,0,0,1,0,1 on consecutive edges, then 0; `rd_addr_done`=0 afterward.
- **Abort:** raise ss_n after 6 bits of a WRITE frame → no rx_valid; rx_data unchanged; FSM returns to IDLE; the next full frame decodes correctly.
- **Flag persistence:** read address, abort a read-data frame after 4 bits, then resend the full read-data frame → it is still routed to READ_DATA and the reply is shifted out.
